// File: rtl/fpga_cfg_loader.sv
// Serial configuration-chain loader: streams bitstream bytes MSB-first into a scan chain
// clocked by a divided prog_clk, and reassembles the chain tail into readback bytes.
module fpga_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DIV       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = $clog2(DIV + 1);
  localparam int unsigned BW = $clog2(CHAIN_LEN + 1);
  localparam logic [PW-1:0] PhaseLast = PW'(DIV - 1);
  localparam logic [BW-1:0] BitLast   = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StShiftLo, StShiftHi, StDone} state_e;

  state_e        state_q;
  logic [PW-1:0] phase_q;
  logic [BW-1:0] bitcnt_q;
  logic [2:0]    nbit_q;
  logic [7:0]    shreg_q;
  logic [6:0]    rb_sh_q;
  logic [7:0]    rb_data_q;
  logic          rb_valid_q, prog_clk_q, in_ready_q, busy_q, done_q, shifting_q;

  logic [7:0] rb_cap, rb_last;

  // Captured byte so far; on a short final byte, left-justify the collected bits.
  always_comb begin
    rb_cap  = {rb_sh_q, ccff_tail};
    rb_last = rb_cap << (3'd7 - nbit_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      bitcnt_q   <= '0;
      nbit_q     <= '0;
      shreg_q    <= '0;
      rb_sh_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      prog_clk_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shifting_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFetch;
            done_q     <= 1'b0;
            bitcnt_q   <= '0;
            nbit_q     <= '0;
            rb_sh_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StFetch: begin
          if (in_valid) begin
            shreg_q    <= in_data;
            phase_q    <= '0;
            in_ready_q <= 1'b0;
            shifting_q <= 1'b1;
            state_q    <= StShiftLo;
          end
        end
        StShiftLo: begin
          if (phase_q == PhaseLast) begin
            phase_q    <= '0;
            rb_sh_q    <= rb_cap[6:0];
            prog_clk_q <= 1'b1;
            state_q    <= StShiftHi;
            if (nbit_q == 3'd7 || bitcnt_q == BitLast) begin
              rb_valid_q <= 1'b1;
              rb_data_q  <= rb_last;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        StShiftHi: begin
          if (phase_q == PhaseLast) begin
            phase_q    <= '0;
            prog_clk_q <= 1'b0;
            bitcnt_q   <= bitcnt_q + BW'(1);
            nbit_q     <= nbit_q + 3'd1;
            shreg_q    <= {shreg_q[6:0], 1'b0};
            if (bitcnt_q == BitLast) begin
              shifting_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else if (nbit_q == 3'd7) begin
              shifting_q <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= StFetch;
            end else begin
              state_q <= StShiftLo;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ccff_head = shifting_q & shreg_q[7];
  assign prog_clk  = prog_clk_q;
  assign in_ready  = in_ready_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench: two loader instances (16-bit/DIV=2 and 10-bit/DIV=1) driving
// behavioural chain models; head bits and readback bytes are checked against queues.
module tb_fpga_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: CHAIN_LEN=16, DIV=2
  logic       rst16 = 1'b1, st16 = 1'b0, v16 = 1'b0, rdy16, pc16, hd16, tl16, rbv16, busy16;
  logic       done16;
  logic [7:0] d16 = '0, rbd16;
  logic [15:0] ch16 = '0, pre16_val = '0;
  logic        pre16_go = 1'b0, pc16_p = 1'b0, rst16_d = 1'b0;

  fpga_cfg_loader #(.CHAIN_LEN(16), .DIV(2)) u_dut16 (
    .clk(clk), .reset(rst16), .start(st16), .in_data(d16), .in_valid(v16), .in_ready(rdy16),
    .prog_clk(pc16), .ccff_head(hd16), .ccff_tail(tl16), .rb_data(rbd16), .rb_valid(rbv16),
    .busy(busy16), .done(done16)
  );

  always @(posedge clk) begin
    pc16_p  <= pc16;
    rst16_d <= rst16;
    if (pre16_go) ch16 <= pre16_val;
    else if (pc16 && !pc16_p) ch16 <= {ch16[14:0], hd16};
  end
  assign tl16 = ch16[15];

  // ---------------- instance B: CHAIN_LEN=10, DIV=1
  logic       rst10 = 1'b1, st10 = 1'b0, v10 = 1'b0, rdy10, pc10, hd10, tl10, rbv10, busy10;
  logic       done10;
  logic [7:0] d10 = '0, rbd10;
  logic [9:0] ch10 = '0, pre10_val = '0;
  logic       pre10_go = 1'b0, pc10_p = 1'b0, rst10_d = 1'b0;
  int         acc10 = 0;

  fpga_cfg_loader #(.CHAIN_LEN(10), .DIV(1)) u_dut10 (
    .clk(clk), .reset(rst10), .start(st10), .in_data(d10), .in_valid(v10), .in_ready(rdy10),
    .prog_clk(pc10), .ccff_head(hd10), .ccff_tail(tl10), .rb_data(rbd10), .rb_valid(rbv10),
    .busy(busy10), .done(done10)
  );

  always @(posedge clk) begin
    pc10_p  <= pc10;
    rst10_d <= rst10;
    if (pre10_go) ch10 <= pre10_val;
    else if (pc10 && !pc10_p) ch10 <= {ch10[8:0], hd10};
    if (v10 && rdy10) acc10++;
  end
  assign tl10 = ch10[9];

  // ---------------- scoreboards and monitors
  bit         q_hd16[$], q_hd10[$];
  logic [7:0] q_rb16[$], q_rb10[$];
  int  rises16 = 0, hi16 = 0, lo16 = 0, rises10 = 0, hi10 = 0, lo10 = 0;
  logic pc16_m = 1'b0, pc10_m = 1'b0;

  always @(negedge clk) begin
    if (rst16_d) begin
      hi16 = 0;
      lo16 = 0;
    end
    if (pc16 && !pc16_m) begin
      rises16++;
      check_eq("lo16_len", lo16, 2);
      lo16 = 0;
      if (q_hd16.size() == 0) check_eq("hd16_q_empty", q_hd16.size(), 1);
      else check_eq("hd16", hd16, q_hd16.pop_front());
    end
    if (pc16) hi16++;
    else begin
      if (pc16_m && !rst16_d) check_eq("hi16_len", hi16, 2);
      hi16 = 0;
      if (busy16 && !rdy16) lo16++;
    end
    if (rbv16) begin
      if (q_rb16.size() == 0) check_eq("rb16_q_empty", q_rb16.size(), 1);
      else check_eq("rb16", rbd16, q_rb16.pop_front());
    end
    if (!busy16 || rdy16) check_eq("idle16_out", {pc16, hd16}, 0);
    pc16_m = pc16;
  end

  always @(negedge clk) begin
    if (rst10_d) begin
      hi10 = 0;
      lo10 = 0;
    end
    if (pc10 && !pc10_m) begin
      rises10++;
      check_eq("lo10_len", lo10, 1);
      lo10 = 0;
      if (q_hd10.size() == 0) check_eq("hd10_q_empty", q_hd10.size(), 1);
      else check_eq("hd10", hd10, q_hd10.pop_front());
    end
    if (pc10) hi10++;
    else begin
      if (pc10_m && !rst10_d) check_eq("hi10_len", hi10, 1);
      hi10 = 0;
      if (busy10 && !rdy10) lo10++;
    end
    if (rbv10) begin
      if (q_rb10.size() == 0) check_eq("rb10_q_empty", q_rb10.size(), 1);
      else check_eq("rb10", rbd10, q_rb10.pop_front());
    end
    if (!busy10 || rdy10) check_eq("idle10_out", {pc10, hd10}, 0);
    pc10_m = pc10;
  end

  // ---------------- drivers (called at a negedge, return at a negedge)
  task automatic preload16(input logic [15:0] v);
    pre16_val = v;
    pre16_go  = 1'b1;
    @(negedge clk);
    pre16_go  = 1'b0;
  endtask

  task automatic send16(input logic [7:0] b);
    d16 = b;
    v16 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rdy16) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check_eq("send16_timeout", rdy16, 1);
  endtask

  task automatic send10(input logic [7:0] b);
    d10 = b;
    v10 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rdy10) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check_eq("send10_timeout", rdy10, 1);
  endtask

  task automatic load16(input logic [15:0] data, input int gap, input logic [15:0] chain,
                        input bit mid_start);
    int r0;
    r0 = rises16;
    for (int i = 15; i >= 0; i--) q_hd16.push_back(data[i]);
    q_rb16.push_back(chain[15:8]);
    q_rb16.push_back(chain[7:0]);
    st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    send16(data[15:8]);
    if (mid_start) begin
      check_eq("busy16_mid", busy16, 1);
      st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0;
    end
    if (gap > 0) begin
      v16 = 1'b0;
      repeat (gap) @(negedge clk);
    end
    send16(data[7:0]);
    v16 = 1'b0;
    for (int i = 0; i < 200 && !done16; i++) @(negedge clk);
    check_eq("done16", done16, 1);
    check_eq("busy16_end", busy16, 0);
    check_eq("rises16", rises16 - r0, 16);
    check_eq("hd16_left", q_hd16.size(), 0);
    check_eq("rb16_left", q_rb16.size(), 0);
    check_eq("chain16", ch16, data);
    repeat (3) @(negedge clk);
    check_eq("done16_hold", done16, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    @(negedge clk);
    preload16(16'hC3F0);
    st16 = 1'b1;  // reset wins over start
    @(negedge clk);
    st16 = 1'b0;
    check_eq("rst_pc", pc16, 0);
    check_eq("rst_hd", hd16, 0);
    check_eq("rst_rdy", rdy16, 0);
    check_eq("rst_busy", busy16, 0);
    check_eq("rst_done", done16, 0);
    check_eq("rst_rbv", rbv16, 0);
    check_eq("rst_rbd", rbd16, 0);
    rst16 = 1'b0;
    rst10 = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", busy16, 0);

    // Back-to-back bytes, readback of the preloaded chain.
    load16(16'hA53C, 0, 16'hC3F0, 1'b0);
    // 20-cycle input stall between bytes, plus an ignored start while busy.
    load16(16'h5AF0, 20, 16'hA53C, 1'b1);

    // Reset during the high phase of bit 5.
    preload16(16'h0000);
    r0 = rises16;
    for (int i = 15; i >= 0; i--) q_hd16.push_back(1'b1);
    st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    d16 = 8'hFF;
    v16 = 1'b1;
    for (int i = 0; i < 200 && !(pc16 && rises16 - r0 == 6); i++) @(negedge clk);
    check_eq("bit5_high", pc16, 1);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    v16 = 1'b0;
    check_eq("mid_rst_pc", pc16, 0);
    check_eq("mid_rst_busy", busy16, 0);
    check_eq("mid_rst_done", done16, 0);
    check_eq("mid_rst_rbv", rbv16, 0);
    check_eq("mid_rst_rbd", rbd16, 0);
    q_hd16.delete();
    repeat (3) @(negedge clk);
    check_eq("mid_rst_rises", rises16 - r0, 6);
    preload16(16'h9D27);
    load16(16'h1234, 0, 16'h9D27, 1'b0);

    // Short chain: 10 bits from 2 bytes, left-justified final readback.
    pre10_val = 10'b10_1100_1110;
    pre10_go  = 1'b1;
    @(negedge clk);
    pre10_go  = 1'b0;
    r0 = rises10;
    acc10 = 0;
    for (int i = 0; i < 10; i++) q_hd10.push_back(1'b1);
    q_rb10.push_back(8'hB3);
    q_rb10.push_back(8'h80);
    st10 = 1'b1;
    @(negedge clk);
    st10 = 1'b0;
    send10(8'hFF);
    send10(8'hC0);
    d10 = 8'h55;  // keep offering data: no third byte may be taken
    v10 = 1'b1;
    for (int i = 0; i < 200 && !done10; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    v10 = 1'b0;
    check_eq("done10", done10, 1);
    check_eq("busy10_end", busy10, 0);
    check_eq("rises10", rises10 - r0, 10);
    check_eq("acc10", acc10, 2);
    check_eq("hd10_left", q_hd10.size(), 0);
    check_eq("rb10_left", q_rb10.size(), 0);
    check_eq("chain10", ch10, 10'h3FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: configuration chain length in bits, at least 1.
REQ-002 Parameter DIV, default 2: clk cycles per prog_clk phase, at least 1.
REQ-003 Port clk, input, 1: the block's only clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle request to begin a load.
REQ-006 Port in_data, input, 8: bitstream byte; the MSB is shifted first.
REQ-007 Port in_valid, input, 1: in_data is valid.
REQ-008 Port in_ready, output, 1: the block accepts in_data this cycle.
REQ-009 Port prog_clk, output, 1: configuration chain clock to the fabric.
REQ-010 Port ccff_head, output, 1: serial data into the chain head.
REQ-011 Port ccff_tail, input, 1: serial data out of the chain tail.
REQ-012 Port rb_data, output, 8: readback byte assembled from ccff_tail.
REQ-013 Port rb_valid, output, 1: one-cycle strobe marking rb_data valid.
REQ-014 Port busy, output, 1: a load is in progress.
REQ-015 Port done, output, 1: the last load completed.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, SHIFT_LO, SHIFT_HI and DONE.
REQ-017 IDLE: start=1 SHALL go to FETCH, clear done, load bit counter 0 and clear the readback shift register; start in any other state SHALL be ignored.
REQ-018 FETCH: in_ready SHALL be 1; on in_valid&in_ready the byte SHALL be latched into an 8-bit shift register and the FSM SHALL go to SHIFT_LO; in_ready SHALL be 0 in every other state.
REQ-019 SHIFT_LO SHALL hold prog_clk=0 and ccff_head=shreg[7] for exactly DIV cycles.
REQ-020 In the last SHIFT_LO cycle, ccff_tail SHALL be shifted into the readback register LSB-side, so the first tail bit ends up at the MSB.
REQ-021 SHIFT_HI SHALL hold prog_clk=1 for exactly DIV cycles, with ccff_head unchanged from SHIFT_LO.
REQ-022 On SHIFT_HI exit the bit counter SHALL increment and shreg SHALL shift left by one.
REQ-023 After SHIFT_HI, if bit counter = CHAIN_LEN the FSM SHALL go to DONE; else if 8 bits of the current byte are consumed it SHALL go to FETCH; else it SHALL go to SHIFT_LO.
REQ-024 One bit SHALL take exactly 2*DIV clk cycles, and CHAIN_LEN rising prog_clk edges SHALL occur per load, no more and no fewer.
REQ-025 The block SHALL accept ceil(CHAIN_LEN/8) bytes per load; the unused LSBs of the final byte SHALL be discarded.
REQ-026 prog_clk SHALL be 0 in IDLE, FETCH and DONE, so an input stall freezes the chain with prog_clk low.
REQ-027 rb_valid SHALL pulse for one cycle, with rb_data = 8 collected tail bits, in the cycle after every 8th captured bit.
REQ-028 If CHAIN_LEN mod 8 != 0, rb_valid SHALL pulse once after the final bit, with the collected bits left-justified and the remaining LSBs 0.
REQ-029 busy SHALL be 1 in FETCH, SHIFT_LO and SHIFT_HI, and 0 otherwise.
REQ-030 DONE SHALL set done=1 and return to IDLE the next cycle; done SHALL stay 1 until the next accepted start or reset.
REQ-031 The phase counter SHALL be ceil(log2(DIV+1)) bits and the bit counter ceil(log2(CHAIN_LEN+1)) bits, and neither SHALL wrap within a load.
REQ-032 ccff_head SHALL be 0 whenever the FSM is not in SHIFT_LO or SHIFT_HI.

Reset
REQ-033 reset=1 at a clk edge SHALL force IDLE and clear all counters and the shift and readback registers.
REQ-034 During and after reset, outputs SHALL be prog_clk=0, ccff_head=0, in_ready=0, busy=0, done=0, rb_valid=0 and rb_data=0x00.
REQ-035 Reset during any state, including mid-prog_clk-high, SHALL take effect the following cycle, with no further prog_clk edge and no rb_valid.
REQ-036 Reset SHALL take priority over a simultaneous start.

Verification
REQ-037 CHAIN_LEN=16, DIV=2, bytes 0xA5 then 0x3C with in_valid held high -> ccff_head sequence 1010010100111100 at 16 prog_clk rises, 4 cycles per bit, done=1 after the 16th bit, busy=0.
REQ-038 Same config, ccff_tail driven by a 16-bit chain model preloaded with 0xC3F0 -> rb_valid twice, rb_data=0xC3 then 0xF0.
REQ-039 CHAIN_LEN=10, DIV=1, bytes 0xFF and 0xC0 -> exactly 10 prog_clk rises, 2 bytes accepted, second rb_data left-justified with LSBs 6..0 = 0.
REQ-040 in_valid deasserted for 20 cycles between bytes -> prog_clk stays 0 and ccff_head stays 0 throughout the gap; bit sequence and edge count unchanged.
REQ-041 reset=1 mid-SHIFT_HI of bit 5 -> next cycle prog_clk=0, busy=0, done=0; a following start reloads from bit 0.
REQ-042 start pulsed while busy=1 -> ignored, and the load completes with the normal edge count.
